// File: rtl/rf_ctrl_pkg.sv
// Shared types and default sizes for the register-file write-port controller.
package rf_ctrl_pkg;

  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 32;

  // Controller modes: sweeping the register file, or arbitrating writeback.
  typedef enum logic {
    INIT = 1'b0,
    ARB  = 1'b1
  } state_t;

  // One writeback request as presented by a requester.
  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: combinational grant, registered last-grant pointer.
// The pointer resets to 1 so requester 0 wins the first tie.
module rr_arbiter2 (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic valid0,
  input  logic valid1,
  output logic grant0,
  output logic grant1
);

  logic last_r;

  // Grant the sole requester, or on a tie the one not granted last.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (en) begin
      grant0 = valid0 & (~valid1 | last_r);
      grant1 = valid1 & (~valid0 | ~last_r);
    end else begin
      grant0 = 1'b0;
      grant1 = 1'b0;
    end
  end

  // Remember who was granted; hold the pointer when nobody is.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_r <= 1'b1;
    end else if (grant0) begin
      last_r <= 1'b0;
    end else if (grant1) begin
      last_r <= 1'b1;
    end else begin
      last_r <= last_r;
    end
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// Write-port sequencer for the 32x32 register file: sweeps all registers to
// INIT_VALUE after reset or on init_start, then round-robins ALU and load
// writebacks onto the single registered write port. Writes to x0 are accepted
// but never reach the port.
// Optional macro RF_WB_FORWARD_EN forwards the in-flight write to the read ports.
module rf_write_arbiter
  import rf_ctrl_pkg::*;
#(
  parameter int          NUM_REGS   = rf_ctrl_pkg::NUM_REGS,
  parameter int          ADDR_W     = rf_ctrl_pkg::ADDR_W,
  parameter int          DATA_W     = rf_ctrl_pkg::DATA_W,
  parameter logic [31:0] INIT_VALUE = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  input  logic              init_start,
  output logic              busy,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  input  logic [ADDR_W-1:0] rs1_addr,
  input  logic [ADDR_W-1:0] rs2_addr,
  input  logic [DATA_W-1:0] rf_rdata1,
  input  logic [DATA_W-1:0] rf_rdata2,
  output logic [DATA_W-1:0] rs1_data,
  output logic [DATA_W-1:0] rs2_data
);

  localparam int CNT_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_REGS - 1);

  state_t           state_r;
  logic [CNT_W-1:0] count_r;
  logic             arb_en_s;
  logic             grant0_s;
  logic             grant1_s;
  wb_req_t          req0_s;
  wb_req_t          req1_s;
  wb_req_t          sel_s;

  // Requests arbitrate only in ARB and only when no sweep is being requested.
  assign arb_en_s = (state_r == ARB) & ~init_start;
  assign busy     = (state_r == INIT);

  rr_arbiter2 u_rr (
    .clk    (clk),
    .rst    (rst),
    .en     (arb_en_s),
    .valid0 (req0_valid),
    .valid1 (req1_valid),
    .grant0 (grant0_s),
    .grant1 (grant1_s)
  );

  assign req0_ready = grant0_s;
  assign req1_ready = grant1_s;

  // Pack the requests and pick the granted one for the write port.
  always_comb begin
    req0_s = '{valid: req0_valid, addr: req0_addr, data: req0_data};
    req1_s = '{valid: req1_valid, addr: req1_addr, data: req1_data};
    if (grant1_s) begin
      sel_s = req1_s;
    end else begin
      sel_s = req0_s;
    end
  end

  // Mode FSM with the registered write port: sweep in INIT, one-cycle writeback in ARB.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= INIT;
      count_r  <= '0;
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      case (state_r)
        INIT: begin
          rf_we    <= 1'b1;
          rf_waddr <= ADDR_W'(count_r);
          rf_wdata <= DATA_W'(INIT_VALUE);
          if (count_r == LAST_CNT) begin
            state_r <= ARB;
            count_r <= '0;
          end else begin
            state_r <= INIT;
            count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        ARB: begin
          count_r <= '0;
          if (init_start) begin
            state_r <= INIT;
            rf_we   <= 1'b0;
          end else if (grant0_s | grant1_s) begin
            state_r  <= ARB;
            rf_we    <= (sel_s.addr != {ADDR_W{1'b0}});
            rf_waddr <= sel_s.addr;
            rf_wdata <= sel_s.data;
          end else begin
            state_r <= ARB;
            rf_we   <= 1'b0;
          end
        end
        default: begin
          state_r <= INIT;
          count_r <= '0;
          rf_we   <= 1'b0;
        end
      endcase
    end
  end

`ifdef RF_WB_FORWARD_EN
  // Bypass the in-flight write to a read port addressing the same non-zero register.
  always_comb begin
    if (rf_we && (rf_waddr == rs1_addr) && (rs1_addr != {ADDR_W{1'b0}})) begin
      rs1_data = rf_wdata;
    end else begin
      rs1_data = rf_rdata1;
    end
    if (rf_we && (rf_waddr == rs2_addr) && (rs2_addr != {ADDR_W{1'b0}})) begin
      rs2_data = rf_wdata;
    end else begin
      rs2_data = rf_rdata2;
    end
  end
`else
  // Read data passes straight through from the register file.
  always_comb begin
    rs1_data = rf_rdata1;
    rs2_data = rf_rdata2;
  end
`endif

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed self-checking bench for rf_write_arbiter.
module tb_rf_write_arbiter;

  localparam int AW = 5;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req0_valid = 1'b0, req1_valid = 1'b0;
  logic          req0_ready, req1_ready;
  logic [AW-1:0] req0_addr = '0, req1_addr = '0;
  logic [DW-1:0] req0_data = '0, req1_data = '0;
  logic          init_start = 1'b0;
  logic          busy, rf_we;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic [AW-1:0] rs1_addr = '0, rs2_addr = '0;
  logic [DW-1:0] rf_rdata1 = '0, rf_rdata2 = '0;
  logic [DW-1:0] rs1_data, rs2_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rf_write_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_addr(req0_addr), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr), .req1_data(req1_data),
    .init_start(init_start), .busy(busy),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .rs1_data(rs1_data), .rs2_data(rs2_data)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Walk a full sweep, checking the write port each cycle; optional held request must stay unready.
  task automatic sweep_check();
    for (int i = 0; i < 32; i++) begin
      tick();
      check("sweep_we", {31'd0, rf_we}, 32'd1);
      check("sweep_addr", {27'd0, rf_waddr}, i);
      check("sweep_data", rf_wdata, 32'h0000_0000);
      check("sweep_busy", {31'd0, busy}, (i == 31) ? 32'd0 : 32'd1);
      if (i != 31) begin
        check("sweep_rdy0", {31'd0, req0_ready}, 32'd0);
      end else begin
        check("sweep_exit_rdy1", {31'd0, req1_ready}, 32'd0);
      end
    end
  endtask

  logic [AW-1:0] exp_addr [4];
  logic [DW-1:0] exp_data [4];

  initial begin
    // Reset, with a request held to show ready stays low.
    req0_valid = 1'b1; req0_addr = 5'd5; req0_data = 32'hDEAD_BEEF;
    tick(); tick(); tick();
    check("rst_busy", {31'd0, busy}, 32'd1);
    check("rst_rdy0", {31'd0, req0_ready}, 32'd0);
    check("rst_rdy1", {31'd0, req1_ready}, 32'd0);
    check("rst_we", {31'd0, rf_we}, 32'd0);
    check("rst_waddr", {27'd0, rf_waddr}, 32'd0);
    check("rst_wdata", rf_wdata, 32'd0);

    // Sweep after reset; req0 is held and becomes ready as soon as busy falls.
    rst = 1'b0;
    init_start = 1'b1;           // ignored during INIT
    sweep_check();
    init_start = 1'b0;
    #1;
    check("t2_rdy0", {31'd0, req0_ready}, 32'd1);
    tick();
    check("t2_we", {31'd0, rf_we}, 32'd1);
    check("t2_waddr", {27'd0, rf_waddr}, 32'd5);
    check("t2_wdata", rf_wdata, 32'hDEAD_BEEF);
    req0_valid = 1'b0;
    #1;
    check("idle_rdy0", {31'd0, req0_ready}, 32'd0);
    tick();
    check("idle_we", {31'd0, rf_we}, 32'd0);

    // Write to x0 via req1: accepted, never reaches the port.
    req1_valid = 1'b1; req1_addr = 5'd0; req1_data = 32'h0000_1234;
    #1;
    check("t4_rdy1", {31'd0, req1_ready}, 32'd1);
    tick();
    check("t4_we", {31'd0, rf_we}, 32'd0);

    // Both valid continuously: req0 (last grant was req1) then alternate.
    req0_valid = 1'b1; req0_addr = 5'd1; req0_data = 32'h0000_0011;
    req1_valid = 1'b1; req1_addr = 5'd2; req1_data = 32'h0000_0022;
    exp_addr[0] = 5'd1; exp_addr[1] = 5'd2; exp_addr[2] = 5'd1; exp_addr[3] = 5'd2;
    exp_data[0] = 32'h11; exp_data[1] = 32'h22; exp_data[2] = 32'h11; exp_data[3] = 32'h22;
    #1;
    for (int k = 0; k < 4; k++) begin
      check("t3_rdy0", {31'd0, req0_ready}, (k % 2 == 0) ? 32'd1 : 32'd0);
      check("t3_rdy1", {31'd0, req1_ready}, (k % 2 == 0) ? 32'd0 : 32'd1);
      tick();
      check("t3_we", {31'd0, rf_we}, 32'd1);
      check("t3_waddr", {27'd0, rf_waddr}, {27'd0, exp_addr[k]});
      check("t3_wdata", rf_wdata, exp_data[k]);
    end
    req1_valid = 1'b0;

    // init_start while req0 valid: init wins, then full sweep, then req0 granted.
    req0_addr = 5'd9; req0_data = 32'h0000_0099;
    init_start = 1'b1;
    #1;
    check("t5_rdy0", {31'd0, req0_ready}, 32'd0);
    check("t5_rdy1", {31'd0, req1_ready}, 32'd0);
    check("t5_busy_pre", {31'd0, busy}, 32'd0);
    tick();
    init_start = 1'b0;
    check("t5_busy", {31'd0, busy}, 32'd1);
    check("t5_we", {31'd0, rf_we}, 32'd0);
    sweep_check();
    check("t5_rdy0_after", {31'd0, req0_ready}, 32'd1);
    tick();
    check("t5_waddr", {27'd0, rf_waddr}, 32'd9);
    check("t5_wdata", rf_wdata, 32'h0000_0099);

    // Forwarding of the in-flight write to the read ports.
    req0_addr = 5'd7; req0_data = 32'hA5A5_A5A5;
    rs1_addr = 5'd7; rs2_addr = 5'd7;
    rf_rdata1 = 32'h0000_0000; rf_rdata2 = 32'h5555_5555;
    tick();
    req0_valid = 1'b0;
    check("t6_we", {31'd0, rf_we}, 32'd1);
    check("t6_waddr", {27'd0, rf_waddr}, 32'd7);
`ifdef RF_WB_FORWARD_EN
    check("t6_rs1", rs1_data, 32'hA5A5_A5A5);
    check("t6_rs2", rs2_data, 32'hA5A5_A5A5);
`else
    check("t6_rs1", rs1_data, 32'h0000_0000);
    check("t6_rs2", rs2_data, 32'h5555_5555);
`endif
    tick();
    check("t6_rs1_idle", rs1_data, 32'h0000_0000);
    check("t6_rs2_idle", rs2_data, 32'h5555_5555);

    // Reset mid-INIT restarts the sweep from register 0.
    init_start = 1'b1;
    tick();
    init_start = 1'b0;
    tick(); tick(); tick();
    check("mid_waddr", {27'd0, rf_waddr}, 32'd2);
    rst = 1'b1;
    tick();
    check("mid_rst_we", {31'd0, rf_we}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd1);
    rst = 1'b0;
    tick();
    check("mid_restart_we", {31'd0, rf_we}, 32'd1);
    check("mid_restart_addr", {27'd0, rf_waddr}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
